bf16_result_collector: RTL and testbench

Response-side endpoint for bf16_accelerator_top. It captures every result/fpcsr beat the accelerator flags with valid, tags it with the issuing operation code, and buffers it in a small FIFO. The FIFO drains to a host or testbench consumer over a ready/valid handshake. It also keeps sticky fpcsr flags and counts drops, and drives a hold signal that the issuer uses to deassert the accelerator's enable.

---
 rtl/bf16_result_collector.sv | 124 ++++++++++++
 tb/tb_bf16_result_collector.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bf16_result_collector.sv
// Response-side collector for bf16_accelerator_top: tags each valid result beat with its
// operation code, buffers it in a first-word-fall-through FIFO, and tracks sticky flags and drops.
module bf16_result_collector #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       acc_valid,
  input  logic [15:0]                acc_result,
  input  logic [3:0]                 acc_fpcsr,
  input  logic [3:0]                 acc_operation,
  output logic                       acc_hold,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_result,
  output logic [3:0]                 out_fpcsr,
  output logic [3:0]                 out_operation,
  output logic [$clog2(DEPTH):0]     count,
  output logic [3:0]                 fpcsr_sticky,
  input  logic                       clr_sticky,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]     FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0]     HOLD_LVL  = CW'(DEPTH - 1);
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

  logic [23:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              acc_hold_q, acc_hold_d;
  logic [3:0]        sticky_q, sticky_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              full_s, empty_s, push_s, pop_s, drop_s;
  logic [3:0]        sticky_base_s;
  logic [DROP_W-1:0] drop_base_s;
  logic [23:0]       head_s;

  // Handshake decode; a full FIFO still accepts a beat in the cycle it is popped.
  always_comb begin
    full_s  = (count_q == FULL_LVL);
    empty_s = (count_q == {CW{1'b0}});
    pop_s   = !empty_s && out_ready;
    push_s  = acc_valid && (!full_s || pop_s);
    drop_s  = acc_valid && full_s && !pop_s;
  end

  // Next-state for pointers, occupancy and the registered hold request.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    acc_hold_d = (count_d >= HOLD_LVL);
  end

  // Sticky flags and drop accounting; same-cycle push/drop events survive a clear.
  always_comb begin
    sticky_base_s = clr_sticky ? 4'b0000 : sticky_q;
    sticky_d      = sticky_base_s | (push_s ? acc_fpcsr : 4'b0000);
    overflow_d    = (clr_sticky ? 1'b0 : overflow_q) | drop_s;
    drop_base_s   = clr_sticky ? {DROP_W{1'b0}} : drop_cnt_q;
    if (drop_s && (drop_base_s != DROP_MAX)) begin
      drop_cnt_d = drop_base_s + DROP_W'(1);
    end else begin
      drop_cnt_d = drop_base_s;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      acc_hold_q <= 1'b0;
      sticky_q   <= 4'b0000;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      acc_hold_q <= acc_hold_d;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_q] <= {acc_operation, acc_fpcsr, acc_result};
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    head_s = empty_s ? 24'h000000 : mem[rd_ptr_q];
  end

  assign out_valid     = !empty_s;
  assign out_result    = head_s[15:0];
  assign out_fpcsr     = head_s[19:16];
  assign out_operation = head_s[23:20];
  assign count         = count_q;
  assign acc_hold      = acc_hold_q;
  assign fpcsr_sticky  = sticky_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_bf16_result_collector.sv
// Directed bench for bf16_result_collector with hand-computed expectations.
module tb_bf16_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        acc_valid = 1'b0;
  logic [15:0] acc_result = 16'h0000;
  logic [3:0]  acc_fpcsr = 4'h0;
  logic [3:0]  acc_operation = 4'h0;
  logic        acc_hold;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [3:0]  out_fpcsr;
  logic [3:0]  out_operation;
  logic [3:0]  count;
  logic [3:0]  fpcsr_sticky;
  logic        clr_sticky = 1'b0;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  bf16_result_collector #(.DEPTH(8), .DROP_W(8)) dut (
    .clk(clk), .reset(reset),
    .acc_valid(acc_valid), .acc_result(acc_result), .acc_fpcsr(acc_fpcsr),
    .acc_operation(acc_operation), .acc_hold(acc_hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_fpcsr(out_fpcsr), .out_operation(out_operation), .count(count),
    .fpcsr_sticky(fpcsr_sticky), .clr_sticky(clr_sticky),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] r, input logic [3:0] f, input logic [3:0] op);
    acc_valid = 1'b1; acc_result = r; acc_fpcsr = f; acc_operation = op;
    tick();
    acc_valid = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_hold", acc_hold, 0);
    check("rst_sticky", fpcsr_sticky, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_result", out_result, 0);
    #10 reset = 1'b1;
    tick();

    // single beat
    beat(16'h3F80, 4'h0, 4'h2);
    check("s_valid", out_valid, 1);
    check("s_result", out_result, 16'h3F80);
    check("s_op", out_operation, 4'h2);
    check("s_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("s_valid_after_pop", out_valid, 0);
    check("s_count_after_pop", count, 0);

    // ordering and tags
    beat(16'h40E8, 4'h0, 4'h7);
    beat(16'h4140, 4'h0, 4'h7);
    beat(16'h7FC0, 4'h1, 4'h3);
    check("o_count", count, 3);
    check("o_sticky", fpcsr_sticky, 4'h1);
    out_ready = 1'b1;
    check("o_r0", out_result, 16'h40E8); check("o_t0", out_operation, 4'h7);
    tick();
    check("o_r1", out_result, 16'h4140); check("o_t1", out_operation, 4'h7);
    tick();
    check("o_r2", out_result, 16'h7FC0); check("o_t2", out_operation, 4'h3);
    check("o_f2", out_fpcsr, 4'h1);
    tick();
    out_ready = 1'b0;
    check("o_empty", count, 0);

    // fill and hold
    for (int i = 0; i < 7; i++) begin
      beat(16'h1000 + 16'(i), 4'h0, 4'h1);
      if (i == 5) check("f_hold_at6", acc_hold, 0);
    end
    check("f_count7", count, 7);
    check("f_hold_at7", acc_hold, 1);
    beat(16'h1007, 4'h0, 4'h1);
    check("f_count8", count, 8);
    check("f_hold_at8", acc_hold, 1);
    beat(16'hDEAD, 4'h0, 4'h1);
    check("f_drop_count", count, 8);
    check("f_ovf", overflow, 1);
    check("f_dropcnt", drop_cnt, 1);
    check("f_head", out_result, 16'h1000);

    // full with simultaneous push and pop
    out_ready = 1'b1;
    beat(16'hBEEF, 4'h0, 4'h5);
    check("pp_count", count, 8);
    check("pp_dropcnt", drop_cnt, 1);
    for (int i = 1; i < 8; i++) begin
      check("pp_order", out_result, 16'h1000 + 16'(i));
      tick();
    end
    check("pp_last", out_result, 16'hBEEF);
    check("pp_last_tag", out_operation, 4'h5);
    tick();
    out_ready = 1'b0;
    check("pp_drained", count, 0);
    check("pp_hold_clear", acc_hold, 0);

    // sticky clear with concurrent push
    beat(16'h0001, 4'h4, 4'h1);
    check("c_sticky_pre", fpcsr_sticky, 4'h5);
    clr_sticky = 1'b1;
    beat(16'h0002, 4'h8, 4'h1);
    clr_sticky = 1'b0;
    check("c_sticky", fpcsr_sticky, 4'h8);
    check("c_ovf", overflow, 0);
    check("c_drop", drop_cnt, 0);
    check("c_count", count, 2);

    // async reset mid-cycle
    for (int i = 0; i < 3; i++) beat(16'h2000 + 16'(i), 4'h0, 4'h1);
    check("a_count5", count, 5);
    #3 reset = 1'b0;
    #1;
    check("a_valid", out_valid, 0);
    check("a_count", count, 0);
    check("a_hold", acc_hold, 0);
    check("a_result", out_result, 0);
    #2 reset = 1'b1;
    acc_valid = 1'b1; acc_result = 16'h4242; acc_fpcsr = 4'h0; acc_operation = 4'h9;
    #0.1;
    check("a_no_bypass", out_valid, 0);
    tick();
    acc_valid = 1'b0;
    check("a_valid_after", out_valid, 1);
    check("a_head", out_result, 16'h4242);
    check("a_count1", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
